// File: rtl/palette_encode.sv
// Colour-to-palette encoder: maps 24-bit pixels to 4-bit indices and writes them
// into a two-bank memory, even pixels to bank 0 and odd pixels to bank 1.
module palette_encode #(
  parameter int unsigned FRAME_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pix_valid,
  input  logic [23:0] pix_rgb,
  output logic        pix_ready,
  output logic [10:0] mem_address,
  output logic [3:0]  mem_data,
  output logic        mem_wren,
  output logic        busy,
  output logic        done,
  output logic [15:0] miss_count
);

  localparam logic [10:0] LastPix = 11'(2 * FRAME_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [15:0] miss_q, miss_d;
  logic        wren_q, wren_d;
  logic        done_q, done_d;
  logic [10:0] addr_q, addr_d;
  logic [3:0]  data_q, data_d;
  logic [3:0]  idx;
  logic        hit;
  logic        last;

  assign last = (cnt_q == LastPix);

  // Exact-match palette; black is a legitimate entry, so it is a hit with index 0.
  always_comb begin
    idx = 4'h0;
    hit = 1'b1;
    case (pix_rgb)
      24'h000066: idx = 4'h1;
      24'hFF0000: idx = 4'h2;
      24'hFF3200: idx = 4'h3;
      24'hFFFF00: idx = 4'h4;
      24'h33FF00: idx = 4'h5;
      24'h009BFF: idx = 4'h6;
      24'h6D33FF: idx = 4'h7;
      24'hFFD393: idx = 4'h8;
      24'hFF99FF: idx = 4'h9;
      24'hFF329F: idx = 4'hA;
      24'h999999: idx = 4'hB;
      24'hFF9999: idx = 4'hC;
      24'hFFFFFF: idx = 4'hD;
      24'h000000: idx = 4'h0;
      default:    hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    miss_d  = miss_q;
    wren_d  = 1'b0;
    done_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
          miss_d  = '0;
        end
      end
      StRun: begin
        if (pix_valid) begin
          wren_d = 1'b1;
          addr_d = {cnt_q[0], cnt_q[10:1]};
          data_d = idx;
          if (!hit && miss_q != 16'hFFFF) miss_d = miss_q + 16'd1;
          if (last) begin
            state_d = StFlush;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 11'd1;
          end
        end
      end
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      miss_q  <= '0;
      wren_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      miss_q  <= miss_d;
      wren_q  <= wren_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign pix_ready   = (state_q == StRun);
  assign busy        = (state_q != StIdle);
  assign mem_wren    = wren_q;
  assign done        = done_q;
  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign miss_count  = miss_q;

endmodule

// File: doc/palette_encode.md
PALETTE_ENCODE -- requirements
Module: palette_encode

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 1024, meaning words per bank; one frame is 2*FRAME_WORDS pixels; legal range 1..1024.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a frame.
REQ-005 SHALL have port pix_valid  input  1  pix_rgb holds a pixel.
REQ-006 SHALL have port pix_rgb  input  24  pixel colour, {R[23:16],G[15:8],B[7:0]}.
REQ-007 SHALL have port pix_ready  output  1  encoder accepts a pixel this cycle.
REQ-008 SHALL have port mem_address  output  11  write address, {bank, word[9:0]}.
REQ-009 SHALL have port mem_data  output  4  palette index to write.
REQ-010 SHALL have port mem_wren  output  1  write strobe, one word per cycle.
REQ-011 SHALL have port busy  output  1  frame in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse on the final write of a frame.
REQ-013 SHALL have port miss_count  output  16  pixels in the current or last frame that matched no palette entry.

Function
REQ-014 SHALL implement states IDLE, RUN and FLUSH.
REQ-015 SHALL move IDLE->RUN on start=1; start in RUN or FLUSH SHALL be ignored.
REQ-016 SHALL, on IDLE->RUN, clear the pixel counter and miss_count.
REQ-017 SHALL drive pix_ready=1 only in RUN; a pixel is accepted when pix_valid=1 and pix_ready=1.
REQ-018 SHALL use a pixel counter p, 0..2*FRAME_WORDS-1, that increments once per accepted pixel.
REQ-019 SHALL route pixel p to bank p[0] (even->0, odd->1) at word p>>1, i.e. mem_address={p[0], p[10:1]}.
REQ-020 SHALL map colour to index by exact 24-bit match: 0x000066->1, 0xFF0000->2, 0xFF3200->3, 0xFFFF00->4, 0x33FF00->5, 0x009BFF->6, 0x6D33FF->7, 0xFFD393->8, 0xFF99FF->9, 0xFF329F->A, 0x999999->B, 0xFF9999->C, 0xFFFFFF->D, 0x000000->0.
REQ-021 SHALL write index 0 for any other colour and increment miss_count, saturating at 0xFFFF.
REQ-022 SHALL register the lookup so that a pixel accepted in cycle N produces mem_wren=1 with its address and data in cycle N+1: fixed latency of 1.
REQ-023 SHALL drive mem_wren=0 in every cycle not required by REQ-022; mem_address and mem_data are don't-care when mem_wren=0.
REQ-024 SHALL sustain one pixel per cycle with no bubbles while pix_valid stays high.
REQ-025 SHALL tolerate pix_valid gaps of any length; the counter holds and no write occurs.
REQ-026 SHALL, on accepting pixel 2*FRAME_WORDS-1, go RUN->FLUSH and drop pix_ready in the next cycle.
REQ-027 SHALL, in FLUSH, issue the final write with done=1 in the same cycle, then go to IDLE.
REQ-028 SHALL assert busy in RUN and FLUSH, and deassert it in IDLE.
REQ-029 SHALL hold miss_count after done until the next start.

Reset
REQ-030 SHALL, when rst_n=0 at a clock edge, set state=IDLE, counter=0, pix_ready=0, mem_wren=0, mem_address=0, mem_data=0, busy=0, done=0 and miss_count=0.
REQ-031 SHALL, on reset mid-frame, drop any pending write (no mem_wren in the cycle after reset) and wait for a new start.
REQ-032 SHALL give reset priority over start and pix_valid in the same cycle.

Verification
REQ-033 SHALL cover: FRAME_WORDS=4, start, then 8 back-to-back pixels 0x000066,0xFF0000,...; response: writes to 0x000,0x400,0x001,0x401,...,0x403 with data 1,2,..., each one cycle after acceptance, and done on the 0x403 write.
REQ-034 SHALL cover: pixel 0x123456 -> mem_data=0, miss_count=1; pixel 0x000000 -> mem_data=0, miss_count unchanged.
REQ-035 SHALL cover: pix_valid toggling 1,0,0,1 -> exactly two writes, to 0x000 and 0x400, with no write in the gap cycles.
REQ-036 SHALL cover: rst_n=0 after 3 of 8 pixels -> mem_wren=0 next cycle and busy=0; a new start restarts writing at 0x000.
REQ-037 SHALL cover: start pulsed while busy -> no effect, and the address sequence continues unchanged.
REQ-038 SHALL cover: FRAME_WORDS=1024 full frame of 0xFFFFFF -> 2048 writes of data 0xD, last address 0x7FF, done once, miss_count=0.
